// File: rtl/smart_home_pkg.sv
// Shared types and default constants for the smart-home controller.
// HVAC state codes are also consumed by the display logic.
package smart_home_pkg;

  localparam int TEMP_W         = 7;
  localparam int DEF_HEAT_ON_TH  = 50;
  localparam int DEF_HEAT_OFF_TH = 55;
  localparam int DEF_COOL_ON_TH  = 80;
  localparam int DEF_COOL_OFF_TH = 75;
  localparam int DEF_MIN_ON      = 16;
  localparam int DEF_DEAD_CYC    = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAT = 3'd1,
    S_COOL = 3'd2,
    S_DEAD = 3'd3,
    S_LOCK = 3'd4
  } hvac_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hvac_sequencer_hold_timer.sv
// Saturating up-counter with clear and terminal-count flag.
// Shared by the minimum on-time and dead-time intervals.
module hold_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_lim,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count toward the limit and hold there; clear has priority.
  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt < i_lim))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == i_lim);

endmodule

// File: rtl/hvac_sequencer.sv
// Heater/cooler sequencer: hysteresis, minimum on-time,
// dead-time interlock and fire-alarm lockout.
module hvac_sequencer #(
  parameter int TEMP_W      = smart_home_pkg::TEMP_W,
  parameter int HEAT_ON_TH  = smart_home_pkg::DEF_HEAT_ON_TH,
  parameter int HEAT_OFF_TH = smart_home_pkg::DEF_HEAT_OFF_TH,
  parameter int COOL_ON_TH  = smart_home_pkg::DEF_COOL_ON_TH,
  parameter int COOL_OFF_TH = smart_home_pkg::DEF_COOL_OFF_TH,
  parameter int MIN_ON      = smart_home_pkg::DEF_MIN_ON,
  parameter int DEAD_CYC    = smart_home_pkg::DEF_DEAD_CYC
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              en,
  input  logic              SFA,
  input  logic [TEMP_W-1:0] ST,
  output logic              heater,
  output logic              cooler,
  output logic [2:0]        state_o,
  output logic              busy
);
  import smart_home_pkg::*;

  localparam int CNT_MAX = max2(MIN_ON, DEAD_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MIN_LIM  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYC - 1);

  localparam logic [TEMP_W-1:0] HON  = TEMP_W'(HEAT_ON_TH);
  localparam logic [TEMP_W-1:0] HOFF = TEMP_W'(HEAT_OFF_TH);
  localparam logic [TEMP_W-1:0] CON  = TEMP_W'(COOL_ON_TH);
  localparam logic [TEMP_W-1:0] COFF = TEMP_W'(COOL_OFF_TH);

  if (!(HEAT_ON_TH <= HEAT_OFF_TH &&
        HEAT_OFF_TH < COOL_OFF_TH &&
        COOL_OFF_TH <= COOL_ON_TH)) begin : g_bad_th
    $fatal(1, "hvac_sequencer: bad threshold ordering");
  end

  if (MIN_ON < 1 || DEAD_CYC < 1) begin : g_bad_tm
    $fatal(1, "hvac_sequencer: MIN_ON and DEAD_CYC must be >= 1");
  end

  hvac_state_t   r_state;
  hvac_state_t   w_next;
  logic          w_clr;
  logic          w_inc;
  logic          w_tc;
  logic [CW-1:0] w_lim;

  logic w_heat_req;
  logic w_cool_req;
  logic w_heat_done;
  logic w_cool_done;

  assign w_heat_req  = (ST <  HON);
  assign w_cool_req  = (ST >  CON);
  assign w_heat_done = (ST >= HOFF);
  assign w_cool_done = (ST <= COFF);

  // Timer restarts on every state change; limit follows the state.
  assign w_clr = (w_next != r_state);
  assign w_inc = busy;
  assign w_lim = (r_state == S_DEAD) ? DEAD_LIM : MIN_LIM;

  hold_timer #(
    .W (CW)
  ) u_timer (
    .clk     (clk),
    .i_rst_n (Rst),
    .i_clr   (w_clr),
    .i_en    (w_inc),
    .i_lim   (w_lim),
    .o_tc    (w_tc)
  );

  // State register; reset drops straight to IDLE.
  always_ff @(posedge clk) begin
    if (!Rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next state: alarm first, then enable, then temperature/timer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (SFA)
          w_next = S_LOCK;
        else if (en && w_heat_req)
          w_next = S_HEAT;
        else if (en && w_cool_req)
          w_next = S_COOL;
      end
      S_HEAT: begin
        if (SFA)
          w_next = S_LOCK;
        else if (!en)
          w_next = S_DEAD;
        else if (w_tc && w_heat_done)
          w_next = S_DEAD;
      end
      S_COOL: begin
        if (SFA)
          w_next = S_LOCK;
        else if (!en)
          w_next = S_DEAD;
        else if (w_tc && w_cool_done)
          w_next = S_DEAD;
      end
      S_DEAD: begin
        if (SFA)
          w_next = S_LOCK;
        else if (w_tc)
          w_next = S_IDLE;
      end
      S_LOCK: begin
        if (!SFA)
          w_next = S_DEAD;
      end
      default: w_next = S_DEAD;
    endcase
  end

  assign heater  = (r_state == S_HEAT);
  assign cooler  = (r_state == S_COOL);
  assign busy    = (r_state == S_HEAT) ||
                   (r_state == S_COOL) ||
                   (r_state == S_DEAD);
  assign state_o = r_state;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Scenario bench for hvac_sequencer.
// Expected states are queued at drive time and checked after the edge.
module tb_hvac_sequencer;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HEAT = 3'd1;
  localparam logic [2:0] COOL = 3'd2;
  localparam logic [2:0] DEAD = 3'd3;
  localparam logic [2:0] LOCK = 3'd4;

  logic       clk = 1'b0;
  logic       Rst = 1'b0;
  logic       en  = 1'b0;
  logic       SFA = 1'b0;
  logic [6:0] ST  = 7'd0;
  logic       heater;
  logic       cooler;
  logic [2:0] state_o;
  logic       busy;

  int n_run  = 0;
  int n_fail = 0;

  logic [2:0] sbq [$];

  hvac_sequencer dut (
    .clk     (clk),
    .Rst     (Rst),
    .en      (en),
    .SFA     (SFA),
    .ST      (ST),
    .heater  (heater),
    .cooler  (cooler),
    .state_o (state_o),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_out(input logic [2:0] s);
    logic h, c, b;
    h = (s == HEAT);
    c = (s == COOL);
    b = (s == HEAT) || (s == COOL) || (s == DEAD);
    return {s, h, c, b};
  endfunction

  function automatic logic [5:0] obs();
    return {state_o, heater, cooler, busy};
  endfunction

  task automatic drive(input logic r, input logic e, input logic s,
                       input logic [6:0] t, input logic [2:0] x);
    @(negedge clk);
    Rst = r;
    en  = e;
    SFA = s;
    ST  = t;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] x;
    for (int i = 0; i <= 4; i++) begin
      if (i <= 1)      drive(1'b0, 1'b1, 1'b0, 7'd20, IDLE);
      else if (i <= 3) drive(1'b1, 1'b1, 1'b0, 7'd20, HEAT);
      else             drive(1'b0, 1'b1, 1'b0, 7'd20, IDLE);
      x = sbq.pop_front();
      n_run++;
      if (obs() !== exp_out(x)) begin
        n_fail++;
        $display("FAIL reset step %0d: got %b want %b",
                 i, obs(), exp_out(x));
      end
    end
  endtask

  task automatic test_heat_cycle();
    logic [2:0] x;
    logic [2:0] e;
    logic [6:0] t;
    for (int i = 0; i <= 22; i++) begin
      t = (i <= 3) ? 7'd40 : 7'd60;
      if (i == 0)       e = IDLE;
      else if (i <= 16) e = HEAT;
      else if (i <= 20) e = DEAD;
      else              e = IDLE;
      drive(i != 0, 1'b1, 1'b0, t, e);
      x = sbq.pop_front();
      n_run++;
      if (obs() !== exp_out(x)) begin
        n_fail++;
        $display("FAIL heat_cycle step %0d: got %b want %b",
                 i, obs(), exp_out(x));
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [2:0] x;
    logic [2:0] e;
    logic [6:0] t;
    for (int i = 0; i <= 49; i++) begin
      if (i == 0)       begin t = 7'd70; e = IDLE; end
      else if (i <= 16) begin t = 7'd40; e = HEAT; end
      else if (i <= 20) begin t = 7'd52; e = HEAT; end
      else if (i == 21) begin t = 7'd55; e = DEAD; end
      else if (i <= 24) begin t = 7'd70; e = DEAD; end
      else if (i == 25) begin t = 7'd70; e = IDLE; end
      else if (i <= 41) begin t = 7'd90; e = COOL; end
      else if (i <= 44) begin t = 7'd78; e = COOL; end
      else if (i <= 48) begin t = 7'd75; e = DEAD; end
      else              begin t = 7'd75; e = IDLE; end
      drive(i != 0, 1'b1, 1'b0, t, e);
      x = sbq.pop_front();
      n_run++;
      if (obs() !== exp_out(x)) begin
        n_fail++;
        $display("FAIL hysteresis step %0d: got %b want %b",
                 i, obs(), exp_out(x));
      end
    end
  endtask

  task automatic test_swing();
    logic [2:0] x;
    logic [2:0] e;
    int both;
    int gap;
    int gap_seen;
    bit was_heat;
    both     = 0;
    gap      = 0;
    gap_seen = -1;
    was_heat = 1'b0;
    for (int i = 0; i <= 24; i++) begin
      if (i == 0)       e = IDLE;
      else if (i <= 16) e = HEAT;
      else if (i <= 20) e = DEAD;
      else if (i == 21) e = IDLE;
      else              e = COOL;
      drive(i != 0, 1'b1, 1'b0, (i <= 1) ? 7'd40 : 7'd100, e);
      if (heater && cooler) both++;
      if (heater) begin
        was_heat = 1'b1;
        gap = 0;
      end else if (cooler) begin
        if (was_heat && gap_seen < 0) gap_seen = gap;
      end else if (was_heat) begin
        gap++;
      end
      x = sbq.pop_front();
      n_run++;
      if (obs() !== exp_out(x)) begin
        n_fail++;
        $display("FAIL swing step %0d: got %b want %b",
                 i, obs(), exp_out(x));
      end
    end
    n_run++;
    if (both !== 0) begin
      n_fail++;
      $display("FAIL swing_overlap: got %0d cycles want 0", both);
    end
    n_run++;
    if (gap_seen < 4) begin
      n_fail++;
      $display("FAIL swing_gap: got %0d idle cycles want >=4", gap_seen);
    end
  endtask

  task automatic test_fire();
    logic [2:0] x;
    logic [2:0] e;
    logic s;
    for (int i = 0; i <= 14; i++) begin
      s = (i >= 5 && i <= 8);
      if (i == 0)       e = IDLE;
      else if (i <= 4)  e = COOL;
      else if (i <= 8)  e = LOCK;
      else if (i <= 12) e = DEAD;
      else if (i == 13) e = IDLE;
      else              e = COOL;
      drive(i != 0, 1'b1, s, 7'd100, e);
      x = sbq.pop_front();
      n_run++;
      if (obs() !== exp_out(x)) begin
        n_fail++;
        $display("FAIL fire step %0d: got %b want %b",
                 i, obs(), exp_out(x));
      end
    end
  endtask

  task automatic test_enable();
    logic [2:0] x;
    logic [2:0] e;
    logic [6:0] t;
    logic r, n, s;
    for (int i = 0; i <= 24; i++) begin
      r = (i != 0) && (i != 23);
      n = 1'b1;
      s = 1'b0;
      if (i == 0)       begin t = 7'd0;   e = IDLE; end
      else if (i <= 3)  begin t = 7'd0;   e = IDLE; n = 1'b0; end
      else if (i <= 5)  begin t = 7'd50;  e = IDLE; end
      else if (i <= 7)  begin t = 7'd80;  e = IDLE; end
      else if (i == 8)  begin t = 7'd0;   e = HEAT; end
      else if (i <= 12) begin t = 7'd0;   e = DEAD; n = 1'b0; end
      else if (i == 13) begin t = 7'd0;   e = IDLE; n = 1'b0; end
      else if (i == 14) begin t = 7'd0;   e = LOCK; n = 1'b0; s = 1'b1; end
      else if (i == 15) begin t = 7'd127; e = LOCK; s = 1'b1; end
      else if (i <= 19) begin t = 7'd127; e = DEAD; end
      else if (i == 20) begin t = 7'd127; e = IDLE; end
      else if (i <= 22) begin t = 7'd127; e = COOL; end
      else if (i == 23) begin t = 7'd127; e = IDLE; end
      else              begin t = 7'd127; e = COOL; end
      drive(r, n, s, t, e);
      x = sbq.pop_front();
      n_run++;
      if (obs() !== exp_out(x)) begin
        n_fail++;
        $display("FAIL enable step %0d: got %b want %b",
                 i, obs(), exp_out(x));
      end
    end
  endtask

  initial begin
    test_reset();
    test_heat_cycle();
    test_hysteresis();
    test_swing();
    test_fire();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
